// File: rtl/asip_pkg.sv
// -----------------------------------------------------------------------------
// asip_pkg
// Shared definitions for the 16-bit ASIP pipeline.
//   ARQ              : datapath width
//   MEMORY_ADDR_SIZE : instruction / jump address width
//   MUL_CYCLES       : shift-add multiplier iterations (one per product bit)
//   alu_op_t         : ALU operation encoding used by decode and execute
//   exe_state_t      : execute-stage FSM states
//   exe_mem_ctrl_t   : control half of the EXE/MEM pipeline register
// -----------------------------------------------------------------------------
package asip_pkg;

   localparam int ARQ              = 16;
   localparam int MEMORY_ADDR_SIZE = 13;
   // One iteration per multiplier bit, so this must track ARQ.
   localparam int MUL_CYCLES       = ARQ;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } exe_state_t;

   typedef struct packed {
      logic valid;
      logic wb_en;
      logic rd_en_mem;
      logic wr_en_mem;
      logic mux_mem;
      logic pc_en;
   } exe_mem_ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, one multiplier bit per clock, product
// truncated to W bits.
//   clk, rst    : clock, asynchronous active-low reset
//   i_start     : load operands and begin (ignored while busy)
//   i_hold      : freeze the iteration in place (including the last one)
//   i_mcand     : multiplicand
//   i_mplier    : multiplier
//   o_busy      : an operation is in progress
//   o_done      : the current clock edge performs the final iteration
//   o_product   : product, valid whenever o_done is high
// -----------------------------------------------------------------------------
module seq_multiplier
   import asip_pkg::*;
#(
   parameter int W = ARQ,
   parameter int N = MUL_CYCLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic         i_hold,
   input  logic [W-1:0] i_mcand,
   input  logic [W-1:0] i_mplier,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_product
);

   localparam int CNT_W = $clog2(N);

   logic [W-1:0]     r_mcand;
   logic [W-1:0]     r_mplier;
   logic [W-1:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   logic             w_step;
   logic [W-1:0]     w_acc_next;

   assign w_step     = r_busy & ~i_hold;
   // Multiplicand shifts left each step, so bits shifted past W drop out:
   // that is exactly the mod 2^W truncation.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // The product is taken combinationally from the last step so the
   // consumer can register it on the same edge as the final iteration.
   assign o_done    = w_step & (r_cnt == CNT_W'(N - 1));
   assign o_product = w_acc_next;
   assign o_busy    = r_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (w_step) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (o_done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 16-bit ASIP pipeline. Computes the ALU result
// (add/sub/xor in one cycle, multiply over MUL_CYCLES cycles), resolves
// jumps against the registered zero flag and drives the EXE/MEM register.
//   clk, rst                  : clock, asynchronous active-low reset
//   valid_in                  : decode presents a live instruction
//   wb_en_in/rd_en_mem_in/wr_en_mem_in/mux_mem_in/pc_en_in : passed to MEM
//   mux_exe_in                : operand B select (0 src2_in, 1 imm_in)
//   jop_lsb_in, jenable_in    : jump condition / instruction is a jump
//   src1_in..imm_in           : operands, src3_in is store data
//   alu_op_in                 : 00 add, 01 sub, 10 mul, 11 xor
//   jaddr_in                  : jump target
//   stall_in                  : MEM cannot accept
//   stall_out                 : upstream must hold
//   flush_out, jtaken_out     : one-cycle pulse for a taken jump
//   jaddr_out                 : registered jump target
//   valid_out..pc_en_out      : EXE/MEM control
//   alu_result_out, store_data_out : EXE/MEM data
//   zero_flag_out             : current zero flag
//   dbg_state_out             : FSM state, for observation only
//
// Handshake: an instruction moves from decode into this stage on a rising
// edge where valid_in is high and stall_out is low (and no flush is in
// progress); stall_out high means decode must hold the same instruction.
// valid_out marks a live EXE/MEM entry; while stall_in is high the entry
// is held unchanged.
// -----------------------------------------------------------------------------
module exe_stage
   import asip_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic                        wb_en_in,
   input  logic                        rd_en_mem_in,
   input  logic                        wr_en_mem_in,
   input  logic                        mux_exe_in,
   input  logic                        mux_mem_in,
   input  logic                        jop_lsb_in,
   input  logic                        jenable_in,
   input  logic                        pc_en_in,
   input  logic [ARQ-1:0]              src1_in,
   input  logic [ARQ-1:0]              src2_in,
   input  logic [ARQ-1:0]              src3_in,
   input  logic [ARQ-1:0]              imm_in,
   input  logic [1:0]                  alu_op_in,
   input  logic [MEMORY_ADDR_SIZE-1:0] jaddr_in,
   input  logic                        stall_in,
   output logic                        stall_out,
   output logic                        flush_out,
   output logic                        jtaken_out,
   output logic [MEMORY_ADDR_SIZE-1:0] jaddr_out,
   output logic                        valid_out,
   output logic                        wb_en_out,
   output logic                        rd_en_mem_out,
   output logic                        wr_en_mem_out,
   output logic                        mux_mem_out,
   output logic                        pc_en_out,
   output logic [ARQ-1:0]              alu_result_out,
   output logic [ARQ-1:0]              store_data_out,
   output logic                        zero_flag_out,
   output exe_state_t                  dbg_state_out
);

   exe_state_t                  r_state;
   exe_state_t                  w_state_next;
   exe_mem_ctrl_t               r_ctrl;
   exe_mem_ctrl_t               r_mul_ctrl;
   exe_mem_ctrl_t               w_in_ctrl;
   logic [ARQ-1:0]              r_alu;
   logic [ARQ-1:0]              r_store;
   logic [ARQ-1:0]              r_mul_src3;
   logic                        r_zero;
   logic                        r_jtaken;
   logic [MEMORY_ADDR_SIZE-1:0] r_jaddr;

   alu_op_t                     w_op;
   logic [ARQ-1:0]              w_opb;
   logic [ARQ-1:0]              w_alu;
   logic                        w_accept;
   logic                        w_is_mul;
   logic                        w_start;
   logic                        w_taken;
   logic                        w_mul_busy;
   logic                        w_mul_done;
   logic [ARQ-1:0]              w_product;

   assign w_op     = alu_op_t'(alu_op_in);
   assign w_opb    = mux_exe_in ? imm_in : src2_in;
   assign w_is_mul = (w_op == ALU_MUL);
   // A taken jump squashes whatever decode shows in the following cycle.
   assign w_accept = (r_state == IDLE) & valid_in & ~stall_in & ~r_jtaken;
   assign w_start  = w_accept & w_is_mul;
   // Flag value from before this instruction; jumps encoded as mul are ignored.
   assign w_taken  = jenable_in & ~w_is_mul & (~jop_lsb_in | r_zero);

   assign w_in_ctrl = '{valid: 1'b1, wb_en: wb_en_in, rd_en_mem: rd_en_mem_in,
                        wr_en_mem: wr_en_mem_in, mux_mem: mux_mem_in,
                        pc_en: pc_en_in};

   always_comb begin
      w_alu = '0;
      case (w_op)
         ALU_ADD: w_alu = src1_in + w_opb;
         ALU_SUB: w_alu = src1_in - w_opb;
         ALU_XOR: w_alu = src1_in ^ w_opb;
         default: w_alu = '0;
      endcase
   end

   seq_multiplier #(.W(ARQ), .N(MUL_CYCLES)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_hold    (stall_in),
      .i_mcand   (src1_in),
      .i_mplier  (w_opb),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_start)    w_state_next = MUL;
         MUL:  if (w_mul_done) w_state_next = IDLE;
         default:              w_state_next = IDLE;
      endcase
   end

   // Multiply control/store data is captured at acceptance and released
   // together with the product.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mul_ctrl <= '0;
         r_mul_src3 <= '0;
      end else if (w_start) begin
         r_mul_ctrl <= w_in_ctrl;
         r_mul_src3 <= src3_in;
      end
   end

   // ---------------- EXE/MEM register and jump pulse ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl   <= '0;
         r_alu    <= '0;
         r_store  <= '0;
         r_zero   <= 1'b0;
         r_jtaken <= 1'b0;
         r_jaddr  <= '0;
      end else begin
         r_jtaken <= 1'b0;
         if (stall_in) begin
            // MEM is blocked: hold the whole register and the flag.
         end else if (w_mul_done) begin
            r_ctrl  <= r_mul_ctrl;
            r_alu   <= w_product;
            r_store <= r_mul_src3;
            r_zero  <= (w_product == '0);
         end else if (w_accept && !w_is_mul) begin
            r_ctrl  <= w_in_ctrl;
            r_alu   <= w_alu;
            r_store <= src3_in;
            r_zero  <= (w_alu == '0);
            if (w_taken) begin
               r_jtaken <= 1'b1;
               r_jaddr  <= jaddr_in;
            end
         end else begin
            // Bubble: drop all control, keep data fields.
            r_ctrl <= '0;
         end
      end
   end

   assign stall_out      = (r_state == MUL) | w_mul_busy | stall_in;
   assign flush_out      = r_jtaken;
   assign jtaken_out     = r_jtaken;
   assign jaddr_out      = r_jaddr;
   assign valid_out      = r_ctrl.valid;
   assign wb_en_out      = r_ctrl.wb_en;
   assign rd_en_mem_out  = r_ctrl.rd_en_mem;
   assign wr_en_mem_out  = r_ctrl.wr_en_mem;
   assign mux_mem_out    = r_ctrl.mux_mem;
   assign pc_en_out      = r_ctrl.pc_en;
   assign alu_result_out = r_alu;
   assign store_data_out = r_store;
   assign zero_flag_out  = r_zero;
   assign dbg_state_out  = r_state;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 16-bit ASIP pipeline, directly downstream of the instruction-decode stage.
- Consumes the decoded control bits and operands (src1/src2/src3/imm, alu_op, jump fields) and computes the ALU result, including an iterative 16-cycle shift-add multiplier for modular-arithmetic kernels.
- Resolves jumps against a registered zero flag.
- Drives the EXE/MEM pipeline register consumed by the memory stage.

Parameters:
- ARQ, 16: datapath width.
- MEMORY_ADDR_SIZE, 13: jump/instruction address width.
- MUL_CYCLES, 16: iterations of the shift-add multiplier; must equal ARQ.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- valid_in  in  1  decode stage presents a live instruction
- wb_en_in, rd_en_mem_in, wr_en_mem_in  in  1 each  write-back / memory-read / memory-write enables
- mux_exe_in  in  1  operand B select: 0 = src2_in, 1 = imm_in
- mux_mem_in  in  1  write-back source select, passed through to MEM
- jop_lsb_in  in  1  jump condition: 0 = unconditional, 1 = jump if zero flag set
- jenable_in  in  1  instruction is a jump
- pc_en_in  in  1  PC enable, passed through
- src1_in, src2_in, src3_in, imm_in  in  ARQ each  operands; src3 carries store data
- alu_op_in  in  2  operation: 00 add, 01 sub, 10 mul (low ARQ bits), 11 xor
- jaddr_in  in  MEMORY_ADDR_SIZE  jump target
- stall_in  in  1  MEM stage cannot accept
- stall_out  out  1  upstream must hold its instruction
- flush_out  out  1  upstream must squash its in-flight instruction
- jtaken_out  out  1  load PC with jaddr_out
- jaddr_out  out  MEMORY_ADDR_SIZE  registered jump target
- valid_out, wb_en_out, rd_en_mem_out, wr_en_mem_out, mux_mem_out, pc_en_out  out  1 each  EXE/MEM register
- alu_result_out, store_data_out  out  ARQ each  EXE/MEM register
- zero_flag_out  out  1  current zero flag

Behaviour:
- Reset (rst low, asynchronous): every output and register clears to 0; FSM returns to IDLE; the multiplier accumulator and counter clear. Reset mid-multiply aborts the operation with no result emitted.
- FSM states: IDLE, MUL.
- Acceptance condition: IDLE & valid_in & !stall_in & !squash. An accepted instruction with alu_op = 10 moves the FSM to MUL. Every other accepted instruction is registered at that edge, so latency is 1 cycle.
- MUL state:
  - Runs MUL_CYCLES iterations, one per clock.
  - Shift-add uses src1 as the multiplicand and operand B as the multiplier. The product is truncated mod 2^ARQ.
  - On the final iteration the FSM returns to IDLE and the EXE/MEM register loads the result with valid_out = 1. Result appears MUL_CYCLES cycles after acceptance.
  - During MUL, valid_out = 0 (bubble).
  - During MUL, stall_out = 1.
- stall_out is combinational: (state == MUL) | stall_in.
- stall_in high:
  - The EXE/MEM register holds.
  - No acceptance occurs.
  - The multiplier also freezes, including on its last iteration.
- Cycles with no acceptance and no MUL completion load valid_out = 0 and clear all enables; data fields hold.
- Arithmetic: add/sub wrap modulo 2^ARQ with no carry out. The zero flag updates only when a valid ALU result is registered (alu_result == 0) and holds otherwise.
- Jumps:
  - On an accepted instruction with jenable_in = 1, taken = !jop_lsb_in | zero_flag, using the flag value before this instruction.
  - If taken, jtaken_out and flush_out pulse high for exactly 1 cycle after the acceptance edge, and jaddr_out is registered.
  - A jump instruction still writes its ALU result, gated by wb_en_in.
- Squash: while flush_out is high, valid_in is ignored. That instruction is treated as not accepted and produces a bubble.
- Simultaneous events:
  - stall_in wins over acceptance.
  - A jump is never in MUL, because jump encodings must not use alu_op = 10; if they do, the jump is ignored and the multiply proceeds.

Decomposition:
- Shared package (asip_pkg): ARQ and MEMORY_ADDR_SIZE constants; alu_op enum {ALU_ADD, ALU_SUB, ALU_MUL, ALU_XOR}; exe_state_t {IDLE, MUL}; a packed struct for the EXE/MEM control bundle.
- One natural sub-module: seq_multiplier. It has start/busy/done/hold handshake and the accumulator/counter.
- The FSM, jump logic and pipeline register stay in exe_stage.

Test Plan:
1. Reset/idle: rst low for 2 cycles, with valid_in = 1 and src1 = 17 → all outputs 0 during reset. After release and 2 idle cycles, valid_out = 0.
2. Add with immediate: src1 = 17, imm = 3, mux_exe = 1, op = 00, wb_en = 1 → next cycle valid_out = 1, alu_result = 20, zero_flag = 0. Sub of 20 − 20 → result 0, zero_flag = 1.
3. Multiply: src1 = 300, src2 = 300, op = 10 → stall_out high for 16 cycles with valid_out = 0, then alu_result = 24464 (90000 mod 65536) and valid_out = 1 for 1 cycle. Assert rst low at iteration 8 in a rerun → no result emitted.
4. Conditional jump: with zero_flag = 1, jenable = 1, jop_lsb = 1, jaddr = 0x0ABC → jtaken_out and flush_out are a 1-cycle pulse, and the next valid_in is squashed. With zero_flag = 0 → no jtaken_out.
5. Backpressure: stall_in held high for 3 cycles during an add → outputs frozen, stall_out = 1, the instruction is accepted only after release, and there is no duplicate valid_out.
6. Store pass-through: wr_en_mem = 1, src3 = 0xBEEF → store_data_out = 0xBEEF and wr_en_mem_out = 1 for exactly 1 cycle.
